fir_tap_chain: RTL
==================

# fir_tap_chain

Parametrised N-tap direct-form FIR segment with sample-valid handshake, double-buffered coefficient bank, fill tracking and a two-stage multiply/add pipeline. It generalises the single multiply-accumulate delay tap to a complete filter section. It sits in the datapath between the sample source and the downstream accumulator/decimator and produces one filtered output per accepted input sample once the window is full.

## Interface
- L, 24, sample width (signed)
- M, 16, coefficient width (signed)
- A, 46, output width (signed)
- N, 8, number of taps (≥2); AW = $clog2(N)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- ena  in  1  global enable; low freezes every register
- clear  in  1  synchronous flush of delay line, fill counter and valid pipeline; coefficients kept
- x_in  in  L  input sample
- x_valid  in  1  x_in accepted on edge where ena & x_valid & !clear
- coef_we  in  1  write coef_data into shadow[coef_addr] (qualified by ena)
- coef_addr  in  AW  shadow bank index; values ≥N ignored
- coef_data  in  M  coefficient value
- coef_commit  in  1  copy whole shadow bank to active bank (qualified by ena)
- y_out  out  A  filtered output, registered
- y_valid  out  1  one-cycle pulse, y_out valid
- primed  out  1  high once N samples accepted since reset/clear

## Operation
- Delay line tap[0..N-1]: on acceptance tap[0]←x_in, tap[i]←tap[i-1].
- Fill counter saturates at N; primed = (count == N). Sample is "windowed" if the count reaches N on its acceptance edge (i.e. the Nth sample and later).
- Stage 1 (edge after acceptance): p[i] ← tap[i] * active[i], full L+M bits; v1 ← windowed.
- Stage 2 (next edge): sum ← Σp[i] at S = L+M+AW bits, sign-extended; y_out ← fit(sum); y_valid ← v1.
- fit: A ≥ S → sign-extend; A < S → see Configuration.
- Non-windowed samples still shift the delay line but produce no y_valid; y_out holds its last value.
- Active bank is read only by stage 1; a commit affects the first stage-1 capture after the commit edge. Samples already in stage 2 use old coefficients.
- coef_we and coef_commit same edge: active gets the pre-write shadow contents; the write lands in shadow only.
- clear with x_valid same edge: clear wins, sample dropped; v1/v2 also zeroed (in-flight outputs discarded); count←0.
- ena low: no shift, no coefficient update, pipeline holds; y_valid held low while ena low, and in-flight results emerge after ena returns.
- Reset: taps, shadow, active, p, sum, count, y_out, y_valid, primed all 0.

## Timing
- Latency: acceptance on edge E0 → y_valid/y_out on the output after edge E0+2 (qualified enabled edges).
- Throughput: one sample per enabled cycle; back-to-back x_valid supported.
- rst asynchronous: outputs go to 0 without waiting for clk; release synchronous to design domain by the integrator.
- primed rises on the output after the Nth acceptance edge; falls on the clear edge or rst.

## Configuration
- FIR_TAP_CHAIN_SAT_EN defined: when A < S, sum outside the A-bit signed range clamps to 2^(A-1)-1 or -2^(A-1).
- Undefined: low A bits of sum taken (two's-complement wrap). No effect when A ≥ S.

## Test plan
- Reset: assert rst mid-cycle with data in flight → y_out=0, y_valid=0, primed=0 immediately; post-reset stream with zero coefs gives y_out=0.
- Impulse: shadow[i]=i+1, commit, feed 7 zeros (no y_valid, primed rises after 8th), then x=1 followed by zeros → y_valid each cycle, y_out = 1,2,…,8 then 0, first output 2 cycles after x=1.
- Stall: same impulse stream with ena low 3 cycles mid-run → identical y_out sequence, gaps only where ena low.
- Shadow bank: write shadow[0]=100 without commit → outputs unchanged; commit with same-edge write shadow[0]=5 → active[0]=100, next commit → 5.
- Saturation (A=40, all coefs 32767, constant x=8388607, sum=2198955884552): with FIR_TAP_CHAIN_SAT_EN y_out=549755813887; without, y_out=-67371000.
- Clear: clear asserted concurrent with x_valid while two results in flight → dropped sample, no further y_valid, primed=0; N new samples needed before next y_valid.

Source files
------------

// File: rtl/fir_tap_chain_if.sv
// fir_tap_chain_if -- sample, coefficient and result bundle for fir_tap_chain.
//
// Parameters: L sample width, M coefficient width, A output width, N taps.
// Signals:
//   ena         global enable, low freezes the filter
//   clear       synchronous flush of delay line, fill count and valid pipeline
//   x_in        input sample (signed, L bits)
//   x_valid     sample strobe
//   coef_we     write coef_data into shadow[coef_addr]
//   coef_addr   shadow bank index (AW bits)
//   coef_data   coefficient value (signed, M bits)
//   coef_commit copy the whole shadow bank into the active bank
//   y_out       filtered output (signed, A bits), registered
//   y_valid     one-cycle result strobe
//   primed      high once N samples have been accepted since reset/clear
//
// Handshake: there is no back-pressure. A sample is taken on every rising
// edge where ena & x_valid & !clear; y_valid marks one result per windowed
// sample and is only ever high while ena is high, so a consumer that samples
// on enabled edges sees each result exactly once.
// Modports: master drives the inputs (source side), slave is the filter.

interface fir_tap_chain_if #(
   parameter int L = 24,
   parameter int M = 16,
   parameter int A = 46,
   parameter int N = 8
) ();
   localparam int AW = $clog2(N);

   logic                ena;
   logic                clear;
   logic signed [L-1:0] x_in;
   logic                x_valid;
   logic                coef_we;
   logic [AW-1:0]       coef_addr;
   logic signed [M-1:0] coef_data;
   logic                coef_commit;
   logic signed [A-1:0] y_out;
   logic                y_valid;
   logic                primed;

   modport master (
      output ena, clear, x_in, x_valid, coef_we, coef_addr, coef_data, coef_commit,
      input  y_out, y_valid, primed
   );

   modport slave (
      input  ena, clear, x_in, x_valid, coef_we, coef_addr, coef_data, coef_commit,
      output y_out, y_valid, primed
   );
endinterface

// File: rtl/fir_tap_chain.sv
// fir_tap_chain -- N-tap direct-form FIR section.
//
// A delay line of N samples is multiplied by an active coefficient bank
// (stage 1, full-precision products) and summed (stage 2, registered into
// y_out). Coefficients are loaded into a shadow bank and copied to the active
// bank on coef_commit, so a running filter switches coefficient sets on one
// edge. One result is produced per accepted sample once the window is full.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  fir_tap_chain_if.slave (see interface file for signal list)
//
// Optional build macro: FIR_TAP_CHAIN_SAT_EN -- when the output is narrower
// than the internal sum, clamp to the A-bit signed range instead of wrapping.

module fir_tap_chain #(
   parameter int L = 24,
   parameter int M = 16,
   parameter int A = 46,
   parameter int N = 8
) (
   input logic            clk,
   input logic            rst,
   fir_tap_chain_if.slave bus
);
   localparam int AW = $clog2(N);
   localparam int P  = L + M;           // product width
   localparam int S  = P + AW;          // sum width, wide enough for N products
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   logic signed [L-1:0] tap    [N];
   logic signed [M-1:0] shadow [N];
   logic signed [M-1:0] active [N];
   logic signed [P-1:0] prod   [N];
   logic [CW-1:0]       count;
   logic                w0;             // windowed flag of the sample just accepted
   logic                v1;             // products in prod[] belong to a windowed sample
   logic                v2;             // y_q holds a result not yet presented
   logic signed [A-1:0] y_q;
   logic                accept;
   logic                windowed;
   logic [S-1:0]        sum;
   logic signed [A-1:0] fit;

   assign accept   = bus.ena & bus.x_valid & ~bus.clear;
   // The count reaches N on this edge when it is already N-1 or saturated.
   assign windowed = accept & (count >= CNT_LAST);

   always_comb begin
      sum = '0;
      for (int i = 0; i < N; i++) begin
         sum = sum + {{(S-P){prod[i][P-1]}}, prod[i]};
      end
   end

   generate
      if (A > S) begin : g_ext
         assign fit = {{(A-S){sum[S-1]}}, sum};
      end else if (A == S) begin : g_same
         assign fit = sum;
      end else begin : g_narrow
`ifdef FIR_TAP_CHAIN_SAT_EN
         // In range when every bit above the A-bit sign position matches it.
         logic in_range;
         assign in_range = (&sum[S-1:A-1]) | ~(|sum[S-1:A-1]);
         assign fit = in_range  ? sum[A-1:0] :
                      sum[S-1] ? {1'b1, {(A-1){1'b0}}} : {1'b0, {(A-1){1'b1}}};
`else
         assign fit = sum[A-1:0];
`endif
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            tap[i]    <= '0;
            shadow[i] <= '0;
            active[i] <= '0;
            prod[i]   <= '0;
         end
         count <= '0;
         w0    <= 1'b0;
         v1    <= 1'b0;
         v2    <= 1'b0;
         y_q   <= '0;
      end else if (bus.ena) begin
         // Commit reads shadow before this edge's write lands.
         if (bus.coef_we && (int'(bus.coef_addr) < N)) begin
            shadow[bus.coef_addr] <= bus.coef_data;
         end
         if (bus.coef_commit) begin
            for (int i = 0; i < N; i++) active[i] <= shadow[i];
         end
         for (int i = 0; i < N; i++) begin
            prod[i] <= $signed({{M{tap[i][L-1]}}, tap[i]}) *
                       $signed({{L{active[i][M-1]}}, active[i]});
         end
         if (bus.clear) begin
            for (int i = 0; i < N; i++) tap[i] <= '0;
            count <= '0;
            w0    <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
         end else begin
            if (accept) begin
               tap[0] <= bus.x_in;
               for (int i = 1; i < N; i++) tap[i] <= tap[i-1];
               if (count != CNT_FULL) count <= count + 1'b1;
            end
            w0 <= windowed;
            v1 <= w0;
            v2 <= v1;
            if (v1) y_q <= fit;
         end
      end
   end

   assign bus.y_out   = y_q;
   // A held result is masked while stalled and shows once ena returns.
   assign bus.y_valid = v2 & bus.ena;
   assign bus.primed  = (count == CNT_FULL);
endmodule
